hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32 core.
- Sits beside the forwarding unit:
  - detects the load-use hazards that forwarding cannot resolve;
  - sequences the multi-cycle mul/div unit in EX (start pulse, wait, release);
  - flushes IF/ID on a taken branch.
- Drives PC, IF/ID, ID/EX and EX/MEM write/bubble controls.
- Keeps a saturating stall-cycle counter and a sticky mul/div timeout flag.

Parameters:
MD_TIMEOUT, 64, max cycles in MDWAIT before forced release (>=2)
CNT_W, 16, width of stallCount

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
MemRead_ex  input  1  EX instruction is a load
rdAddr_ex  input  5  EX destination register
rs1Addr_id  input  5  ID source 1
rs2Addr_id  input  5  ID source 2
rs1Used_id  input  1  ID instruction reads rs1
rs2Used_id  input  1  ID instruction reads rs2
MulDiv_ex  input  1  EX instruction is mul/div
MulDiv_done  input  1  mul/div result valid (1-cycle pulse)
BranchTaken_ex  input  1  EX branch/jump resolved taken
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register enable
IFIDFlush  output  1  IF/ID cleared to NOP
IDEXWrite  output  1  ID/EX register enable
IDEXBubble  output  1  ID/EX loaded with NOP
EXMEMBubble  output  1  EX/MEM loaded with NOP
MulDiv_start  output  1  start pulse to mul/div unit
mdTimeout  output  1  sticky: a mul/div wait timed out
stallCount  output  CNT_W  saturating count of stall cycles
state  output  2  FSM state (RUN=0, MDWAIT=1)

Behaviour:
- Default values: PCWrite=IFIDWrite=IDEXWrite=1; IFIDFlush=IDEXBubble=EXMEMBubble=MulDiv_start=0.
- Control outputs are combinational from state and inputs. mdTimeout, stallCount and state are registered.
- Reset:
  - state=RUN, mdTimeout=0, stallCount=0, wait counter=0.
  - Control outputs take their RUN values from the inputs during the reset cycle.
- RUN, priority high to low:
  1. BranchTaken_ex: IFIDFlush=1, IDEXBubble=1, PCWrite=1 (redirect). Load-use is ignored in this cycle. Stay in RUN.
  2. MulDiv_ex: MulDiv_start=1 for exactly this cycle, and all RUN stall controls apply this cycle: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1. Next state MDWAIT; wait counter cleared to 0.
  3. Load-use: MemRead_ex && rdAddr_ex!=0 && ((rs1Used_id && rs1Addr_id==rdAddr_ex) || (rs2Used_id && rs2Addr_id==rdAddr_ex)). Response: PCWrite=0, IFIDWrite=0, IDEXBubble=1. One cycle only; stay in RUN.
  - MulDiv_done is ignored in RUN. The mul/div latency is >=1 cycle after start.
- MDWAIT:
  - If MulDiv_done: defaults apply (EX result advances this cycle); next state RUN.
  - Else if wait counter == MD_TIMEOUT-1: defaults apply; mdTimeout<=1; next state RUN.
  - Otherwise: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1; wait counter increments.
  - BranchTaken_ex, MemRead_ex and load-use inputs are ignored.
  - MulDiv_start is never asserted in MDWAIT, even if MulDiv_ex stays high.
- stallCount:
  - Increments by 1 on every cycle where PCWrite==0; saturates at all-ones.
  - Branch-flush cycles are not counted.
- Back-to-back mul/div: the cycle after release, RUN sees the new EX instruction and issues a fresh start.
- Reset mid-MDWAIT: returns to RUN next edge; no start is re-issued for the abandoned instruction; mdTimeout is cleared.

Test Plan:
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for one cycle.
  -> That cycle: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  -> Next cycle (inputs cleared): defaults.
  -> stallCount=1.
- Load-use exclusions:
  - rdAddr_ex=0 with rs1Addr_id=0, rs1Used_id=1 -> no stall.
  - rs1 match with rs1Used_id=0 -> no stall.
- Mul/div: MulDiv_ex=1, MulDiv_done pulses 3 cycles after start.
  -> MulDiv_start=1 for exactly 1 cycle.
  -> Stall outputs held through the wait, released in the done cycle.
  -> state returns to 0; stallCount=3.
- Timeout: MD_TIMEOUT=4, MulDiv_done never asserted.
  -> Release after 4 MDWAIT cycles; mdTimeout=1 and stays 1 until rst.
- Branch priority: BranchTaken_ex=1 together with a load-use match.
  -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; stallCount unchanged.
- Reset in MDWAIT: rst=1 for 1 cycle at wait cycle 2.
  -> state=0, stallCount=0, mdTimeout=0; MulDiv_start not re-asserted unless MulDiv_ex is seen again in RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, mul/div and branch hazard controller for the 5-stage RV32 core
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic             MulDiv_ex,
    input  logic             MulDiv_done,
    input  logic             BranchTaken_ex,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXBubble,
    output logic             EXMEMBubble,
    output logic             MulDiv_start,
    output logic             mdTimeout,
    output logic [CNT_W-1:0] stallCount,
    output logic [1:0]       state
);

    localparam int WAIT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDWAIT = 2'd1
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               md_timeout_q, md_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               load_use;

    always_comb begin
        load_use = MemRead_ex && (rdAddr_ex != 5'd0) &&
                   ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
                    (rs2Used_id && (rs2Addr_id == rdAddr_ex)));
    end

    // During reset the controls follow the RUN decode so the pipeline sees sane enables.
    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IFIDFlush    = 1'b0;
        IDEXBubble   = 1'b0;
        EXMEMBubble  = 1'b0;
        MulDiv_start = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        md_timeout_d = md_timeout_q;

        if (rst || (state_q == RUN)) begin
            if (BranchTaken_ex) begin
                IFIDFlush  = 1'b1;
                IDEXBubble = 1'b1;
            end else if (MulDiv_ex) begin
                MulDiv_start = 1'b1;
                PCWrite      = 1'b0;
                IFIDWrite    = 1'b0;
                IDEXWrite    = 1'b0;
                EXMEMBubble  = 1'b1;
                state_d      = MDWAIT;
                wait_d       = '0;
            end else if (load_use) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end
        end else if (state_q == MDWAIT) begin
            if (MulDiv_done) begin
                state_d = RUN;
            end else if (wait_q == WAIT_LAST) begin
                md_timeout_d = 1'b1;
                state_d      = RUN;
            end else begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEXWrite   = 1'b0;
                EXMEMBubble = 1'b1;
                wait_d      = wait_q + 1'b1;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            wait_q       <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mdTimeout  = md_timeout_q;
    assign stallCount = stall_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, MulDiv_start}
    localparam logic [6:0] CTL_DEF   = 7'b1101000;
    localparam logic [6:0] CTL_LU    = 7'b0001100;
    localparam logic [6:0] CTL_BR    = 7'b1111100;
    localparam logic [6:0] CTL_START = 7'b0000011;
    localparam logic [6:0] CTL_STALL = 7'b0000010;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemRead_ex, rs1Used_id, rs2Used_id;
    logic             MulDiv_ex, MulDiv_done, BranchTaken_ex;
    logic [4:0]       rdAddr_ex, rs1Addr_id, rs2Addr_id;
    logic             PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble;
    logic             MulDiv_start, mdTimeout;
    logic [CNT_W-1:0] stallCount;
    logic [1:0]       state;
    logic [6:0]       ctl;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
        .MulDiv_ex(MulDiv_ex), .MulDiv_done(MulDiv_done),
        .BranchTaken_ex(BranchTaken_ex),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXWrite(IDEXWrite), .IDEXBubble(IDEXBubble), .EXMEMBubble(EXMEMBubble),
        .MulDiv_start(MulDiv_start), .mdTimeout(mdTimeout),
        .stallCount(stallCount), .state(state)
    );

    always #5 clk = ~clk;

    assign ctl = {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, MulDiv_start};

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic [6:0] exp_ctl;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
        rs1Used_id = 0; rs2Used_id = 0; MulDiv_ex = 0; MulDiv_done = 0;
        BranchTaken_ex = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " state"}, 32'(state), 32'(0));
        chk({tag, " stallCount"}, 32'(stallCount), 32'(exp_cnt));
    endtask

    initial begin
        //          mr    rd     rs1    rs2    u1    u2    br    expected
        vecs[0] = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, CTL_LU};
        vecs[1] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, CTL_DEF};
        vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, CTL_DEF};
        vecs[3] = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 1'b0, CTL_DEF};
        vecs[4] = '{1'b1, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, CTL_LU};
        vecs[5] = '{1'b0, 5'd7,  5'd7,  5'd0,  1'b1, 1'b0, 1'b0, CTL_DEF};
        vecs[6] = '{1'b1, 5'd9,  5'd0,  5'd9,  1'b0, 1'b1, 1'b1, CTL_BR};
        vecs[7] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, CTL_BR};
        vecs[8] = '{1'b1, 5'd3,  5'd3,  5'd3,  1'b1, 1'b1, 1'b0, CTL_LU};
        vecs[9] = '{1'b1, 5'd3,  5'd4,  5'd3,  1'b1, 1'b0, 1'b0, CTL_DEF};

        clear_inputs();
        rst = 1;
        step();
        step();
        chk_regs("reset");
        chk("reset mdTimeout", 32'(mdTimeout), 32'(0));
        chk("reset ctl", 32'(ctl), 32'(CTL_DEF));
        rst = 0;

        for (int i = 0; i < 10; i++) begin
            MemRead_ex = vecs[i].mr; rdAddr_ex = vecs[i].rd;
            rs1Addr_id = vecs[i].rs1; rs2Addr_id = vecs[i].rs2;
            rs1Used_id = vecs[i].u1; rs2Used_id = vecs[i].u2;
            BranchTaken_ex = vecs[i].br;
            #1;
            chk($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
            if (!vecs[i].exp_ctl[6]) exp_cnt++;
            step();
            chk($sformatf("vec%0d stallCount", i), 32'(stallCount), 32'(exp_cnt));
        end

        // mul/div with done three cycles after start, then a back-to-back op
        clear_inputs();
        MulDiv_ex = 1;
        #1;
        chk("md start ctl", 32'(ctl), 32'(CTL_START));
        step(); exp_cnt++;
        chk("md wait state", 32'(state), 32'(1));
        chk("md wait1 ctl", 32'(ctl), 32'(CTL_STALL));
        step(); exp_cnt++;
        chk("md wait2 ctl", 32'(ctl), 32'(CTL_STALL));
        step(); exp_cnt++;
        MulDiv_done = 1;
        #1;
        chk("md done ctl", 32'(ctl), 32'(CTL_DEF));
        step();
        MulDiv_done = 0;
        chk_regs("md release");
        #1;
        chk("md b2b start ctl", 32'(ctl), 32'(CTL_START));
        step(); exp_cnt++;
        MulDiv_done = 1;
        #1;
        chk("md b2b done ctl", 32'(ctl), 32'(CTL_DEF));
        step();
        clear_inputs();
        chk_regs("md b2b release");
        chk("md mdTimeout", 32'(mdTimeout), 32'(0));

        // timeout: done never arrives, release on the fourth wait cycle
        MulDiv_ex = 1;
        #1;
        chk("to start ctl", 32'(ctl), 32'(CTL_START));
        step(); exp_cnt++;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("to wait%0d ctl", w), 32'(ctl), 32'(CTL_STALL));
            step(); exp_cnt++;
        end
        chk("to release ctl", 32'(ctl), 32'(CTL_DEF));
        chk("to pre mdTimeout", 32'(mdTimeout), 32'(0));
        step();
        MulDiv_ex = 0;
        chk_regs("to release");
        chk("to mdTimeout", 32'(mdTimeout), 32'(1));
        MemRead_ex = 1; rdAddr_ex = 5'd12; rs1Addr_id = 5'd12; rs1Used_id = 1;
        #1;
        chk("to lu ctl", 32'(ctl), 32'(CTL_LU));
        step(); exp_cnt++;
        clear_inputs();
        step();
        chk("to sticky mdTimeout", 32'(mdTimeout), 32'(1));
        chk("to sticky stallCount", 32'(stallCount), 32'(exp_cnt));

        // reset during the third wait cycle
        MulDiv_ex = 1;
        step();
        step();
        step();
        chk("rw pre state", 32'(state), 32'(1));
        rst = 1;
        MulDiv_ex = 0;
        #1;
        chk("rw reset ctl", 32'(ctl), 32'(CTL_DEF));
        step();
        rst = 0;
        exp_cnt = 0;
        chk_regs("rw after");
        chk("rw mdTimeout", 32'(mdTimeout), 32'(0));
        chk("rw no restart ctl", 32'(ctl), 32'(CTL_DEF));
        step();
        chk("rw idle state", 32'(state), 32'(0));
        MulDiv_ex = 1;
        #1;
        chk("rw new start ctl", 32'(ctl), 32'(CTL_START));
        step(); exp_cnt++;
        MulDiv_done = 1;
        step();
        clear_inputs();
        chk_regs("rw final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
